// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if: buttons, frame strobe and ball-engine flags in, ball-engine controls and HUD out
interface pong_match_ctrl_if;
  logic       in_ani_stb;
  logic       in_start_btn;
  logic       in_pause_btn;
  logic       in_left_score;
  logic       in_right_score;
  logic       out_ball_start;
  logic       out_ball_reset;
  logic       out_animate;
  logic [3:0] out_left_points;
  logic [3:0] out_right_points;
  logic [1:0] out_winner;
  logic [2:0] out_state;
  modport master (
    output in_ani_stb, in_start_btn, in_pause_btn, in_left_score, in_right_score,
    input  out_ball_start, out_ball_reset, out_animate, out_left_points,
           out_right_points, out_winner, out_state
  );
  modport slave (
    input  in_ani_stb, in_start_btn, in_pause_btn, in_left_score, in_right_score,
    output out_ball_start, out_ball_reset, out_animate, out_left_points,
           out_right_points, out_winner, out_state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: serve/play/pause/point/gameover sequencer driving the ball engine and keeping score
module pong_match_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_POINTS   = 5
) (
  input logic in_clock,
  input logic in_reset_n,
  pong_match_ctrl_if.slave b
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, PAUSED, POINT, GAMEOVER} state_t;
  state_t state;
  logic [3:0] prev, edg;
  logic [7:0] cnt;
  logic first, se, pe, le, re, tick, last, win_l, win_r;
  assign {se, pe, le, re} = edg;
  // strobes in the first cycle of a timed state never count
  assign tick = !first && b.in_ani_stb;
  assign last = tick && cnt == 8'd1;
  assign win_l = b.out_left_points == 4'(WIN_POINTS);
  assign win_r = b.out_right_points == 4'(WIN_POINTS);
  assign b.out_state = state;
  always_ff @(posedge in_clock or negedge in_reset_n)
    if (!in_reset_n) begin
      state <= IDLE;
      prev <= '0;
      edg <= '0;
      cnt <= '0;
      first <= 1'b0;
      b.out_ball_start <= 1'b0;
      b.out_ball_reset <= 1'b0;
      b.out_animate <= 1'b0;
      b.out_left_points <= '0;
      b.out_right_points <= '0;
      b.out_winner <= '0;
    end else begin
      prev <= {b.in_start_btn, b.in_pause_btn, b.in_left_score, b.in_right_score};
      edg <= {b.in_start_btn, b.in_pause_btn, b.in_left_score, b.in_right_score} & ~prev;
      b.out_ball_start <= 1'b0;
      b.out_ball_reset <= 1'b0;
      first <= 1'b0;
      case (state)
        IDLE: if (se) begin
          state <= SERVE;
          cnt <= 8'(SERVE_FRAMES);
          first <= 1'b1;
          b.out_ball_start <= 1'b1;
          b.out_ball_reset <= 1'b1;
        end
        SERVE: begin
          if (tick) cnt <= cnt - 8'd1;
          if (last) begin
            state <= PLAY;
            b.out_animate <= 1'b1;
          end
        end
        PLAY:
          if (le || re) begin
            state <= POINT;
            cnt <= 8'(POINT_FRAMES);
            first <= 1'b1;
            b.out_animate <= 1'b0;
            if (le && !re) b.out_left_points <= b.out_left_points + 4'd1;
            if (re && !le) b.out_right_points <= b.out_right_points + 4'd1;
          end else if (pe) begin
            state <= PAUSED;
            b.out_animate <= 1'b0;
          end
        PAUSED: if (pe) begin
          state <= PLAY;
          b.out_animate <= 1'b1;
        end
        POINT: begin
          if (tick) cnt <= cnt - 8'd1;
          if (last && (win_l || win_r)) begin
            state <= GAMEOVER;
            b.out_winner <= win_l ? 2'b01 : 2'b10;
          end else if (last) begin
            state <= SERVE;
            cnt <= 8'(SERVE_FRAMES);
            first <= 1'b1;
            b.out_ball_start <= 1'b1;
          end
        end
        GAMEOVER: if (se) begin
          state <= SERVE;
          cnt <= 8'(SERVE_FRAMES);
          first <= 1'b1;
          b.out_ball_start <= 1'b1;
          b.out_ball_reset <= 1'b1;
          b.out_left_points <= '0;
          b.out_right_points <= '0;
          b.out_winner <= '0;
        end
        default: begin
          state <= IDLE;
          b.out_animate <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: table-driven match scenarios with a scoreboard queue plus reset and held-flag sequences
module tb_pong_match_ctrl;
  localparam int SF = 60;
  localparam int PF = 90;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  pong_match_ctrl_if b();
  pong_match_ctrl #(.SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_POINTS(5)) dut (
    .in_clock(clk), .in_reset_n(rst_n), .b(b)
  );
  typedef enum {A_START, A_SERVE, A_LEFT, A_RIGHT, A_BOTH, A_POINT, A_PAUSE, A_PRIGHT, A_LPAUSED} act_t;
  typedef struct {
    act_t act;
    int st, l, r, w, a, ns, nr;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];
  int compared = 0, failed = 0, n_start = 0, n_reset = 0, serve_str = 0, point_str = 0;
  int prev_st = 0;
  task automatic chk(input string n, input int got, input int exp);
    compared++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic [3:0] m, input logic v);
    if (m[3]) b.in_start_btn = v;
    if (m[2]) b.in_pause_btn = v;
    if (m[1]) b.in_left_score = v;
    if (m[0]) b.in_right_score = v;
  endtask
  task automatic wait_leave(input int s);
    int n = 0;
    while (int'(b.out_state) == s && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      compared++;
      failed++;
      $display("FAIL wait_leave: still in state %0d after 2000 cycles, expected exit", s);
    end
  endtask
  task automatic run_action(input act_t a);
    case (a)
      A_START:   begin drive(4'b1000, 1); tick(3); drive(4'b1000, 0); tick(3); end
      A_PAUSE:   begin drive(4'b0100, 1); tick(3); drive(4'b0100, 0); tick(3); end
      A_LEFT:    begin drive(4'b0010, 1); tick(4); end
      A_RIGHT:   begin drive(4'b0001, 1); tick(4); end
      A_BOTH:    begin drive(4'b0011, 1); tick(4); end
      A_PRIGHT:  begin drive(4'b0101, 1); tick(3); drive(4'b0100, 0); tick(1); end
      A_LPAUSED: begin drive(4'b0010, 1); tick(4); drive(4'b0010, 0); tick(2); end
      A_SERVE:   begin wait_leave(1); tick(1); end
      A_POINT:   begin wait_leave(4); tick(1); drive(4'b0011, 0); tick(1); end
      default:   tick(1);
    endcase
  endtask
  function automatic void add(act_t a, int st, int l, int r, int w, int an, int ns, int nr);
    tbl.push_back('{a, st, l, r, w, an, ns, nr});
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, int'(b.out_state), 0);
    chk({tag, "_left"}, int'(b.out_left_points), 0);
    chk({tag, "_right"}, int'(b.out_right_points), 0);
    chk({tag, "_winner"}, int'(b.out_winner), 0);
    chk({tag, "_animate"}, int'(b.out_animate), 0);
    chk({tag, "_pulses"}, int'(b.out_ball_start) + int'(b.out_ball_reset), 0);
  endtask
  always @(negedge clk) begin
    int st;
    st = int'(b.out_state);
    chk("animate_vs_play", int'(b.out_animate), int'(st == 2));
    if (b.out_ball_start || b.out_ball_reset) chk("pulse_at_serve_entry", int'(st == 1 && prev_st != 1), 1);
    n_start += int'(b.out_ball_start);
    n_reset += int'(b.out_ball_reset);
    if (st == 1) serve_str = (prev_st != 1) ? 0 : serve_str + int'(b.in_ani_stb);
    if (st == 4) point_str = (prev_st != 4) ? 0 : point_str + int'(b.in_ani_stb);
    if (st == 2 && prev_st == 1) chk("serve_strobes", serve_str, SF);
    if (st == 1 && prev_st == 4) chk("point_strobes", point_str, PF);
    prev_st = st;
  end
  initial begin
    int k = 0;
    b.in_ani_stb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      b.in_ani_stb = (k % 3 == 0);
    end
  end
  initial begin
    vec_t e;
    int s0, r0;
    drive(4'b1111, 0);
    #2 rst_n = 1'b0;
    tick(3);
    chk_zero("in_reset");
    #2 rst_n = 1'b1;
    tick(2);
    chk_zero("after_reset");
    add(A_START, 1, 0, 0, 0, 0, 1, 1);
    add(A_SERVE, 2, 0, 0, 0, 1, 0, 0);
    add(A_RIGHT, 4, 0, 1, 0, 0, 0, 0);
    add(A_POINT, 1, 0, 1, 0, 0, 1, 0);
    add(A_SERVE, 2, 0, 1, 0, 1, 0, 0);
    add(A_PAUSE, 3, 0, 1, 0, 0, 0, 0);
    add(A_LPAUSED, 3, 0, 1, 0, 0, 0, 0);
    add(A_PAUSE, 2, 0, 1, 0, 1, 0, 0);
    add(A_BOTH, 4, 0, 1, 0, 0, 0, 0);
    add(A_POINT, 1, 0, 1, 0, 0, 1, 0);
    add(A_SERVE, 2, 0, 1, 0, 1, 0, 0);
    add(A_PRIGHT, 4, 0, 2, 0, 0, 0, 0);
    add(A_POINT, 1, 0, 2, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      add(A_SERVE, 2, i - 1, 2, 0, 1, 0, 0);
      add(A_LEFT, 4, i, 2, 0, 0, 0, 0);
      add(A_POINT, i == 5 ? 5 : 1, i, 2, i == 5 ? 1 : 0, 0, i == 5 ? 0 : 1, 0);
    end
    add(A_START, 1, 0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 3; i++) begin
      add(A_SERVE, 2, i - 1, 0, 0, 1, 0, 0);
      add(A_LEFT, 4, i, 0, 0, 0, 0, 0);
      add(A_POINT, 1, i, 0, 0, 0, 1, 0);
    end
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i]);
      s0 = n_start;
      r0 = n_reset;
      run_action(tbl[i].act);
      e = exp_q.pop_front();
      chk($sformatf("row%0d_state", i), int'(b.out_state), e.st);
      chk($sformatf("row%0d_left", i), int'(b.out_left_points), e.l);
      chk($sformatf("row%0d_right", i), int'(b.out_right_points), e.r);
      chk($sformatf("row%0d_winner", i), int'(b.out_winner), e.w);
      chk($sformatf("row%0d_animate", i), int'(b.out_animate), e.a);
      chk($sformatf("row%0d_starts", i), n_start - s0, e.ns);
      chk($sformatf("row%0d_resets", i), n_reset - r0, e.nr);
    end
    chk("midserve_left", int'(b.out_left_points), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    s0 = n_start;
    r0 = n_reset;
    tick(2);
    #3 rst_n = 1'b1;
    tick(5);
    chk_zero("post_midreset");
    chk("post_midreset_starts", n_start - s0, 0);
    chk("post_midreset_resets", n_reset - r0, 0);
    run_action(A_START);
    run_action(A_SERVE);
    chk("hold_play", int'(b.out_state), 2);
    drive(4'b0001, 1);
    tick(200);
    chk("hold_right_points", int'(b.out_right_points), 1);
    chk("hold_state", int'(b.out_state), 4);
    s0 = n_start;
    wait_leave(4);
    tick(1);
    drive(4'b0001, 0);
    chk("hold_reserve_state", int'(b.out_state), 1);
    chk("hold_reserve_right", int'(b.out_right_points), 1);
    chk("hold_reserve_starts", n_start - s0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the pong datapath. It sits between the player buttons and the ball engine, and decides when the ball is served, animated, paused and re-centred. It also keeps the per-side point totals and declares a winner. It drives the ball engine's start, reset and animate inputs and consumes the ball engine's left/right score flags.

## Interface

Parameters:
- SERVE_FRAMES, 60: frames of ani-strobe waited in SERVE before play begins (1..255)
- POINT_FRAMES, 90: frames held in POINT after a score (1..255)
- WIN_POINTS, 5: points needed to win the match (1..15)

Ports:
- in_clock  input  1  base clock
- in_reset_n  input  1  asynchronous, active-low reset
- in_ani_stb  input  1  one-cycle frame strobe, the same strobe fed to the ball engine
- in_start_btn  input  1  start button, synchronous level
- in_pause_btn  input  1  pause button, synchronous level
- in_left_score  input  1  ball engine left-scored flag (level, held until the ball is restarted)
- in_right_score  input  1  ball engine right-scored flag (level)
- out_ball_start  output  1  one-cycle pulse to the ball engine start input
- out_ball_reset  output  1  one-cycle pulse to the ball engine reset input (active high)
- out_animate  output  1  ball engine animate enable
- out_left_points  output  4  left player total
- out_right_points  output  4  right player total
- out_winner  output  2  00 none, 01 left, 10 right
- out_state  output  3  current state encoding, for the HUD

## Operation

- Clock and reset: one clock, in_clock. Reset is asynchronous and active-low on in_reset_n.
- Button and score inputs are rising-edge detected internally, using registered previous values. An "edge" below means a 0→1 transition on that input.
- Frame counter: 8 bits. It loads on state entry and decrements only on cycles where in_ani_stb=1.
- States and encodings:
  - IDLE (0): out_animate=0.
    - start edge → SERVE, with out_ball_reset pulse and out_ball_start pulse.
  - SERVE (1): counter loads SERVE_FRAMES.
    - When the counter reaches 0 on an in_ani_stb cycle → PLAY.
    - Pause and start edges are ignored.
  - PLAY (2): out_animate=1.
    - left score edge: out_left_points++ → POINT.
    - right score edge: out_right_points++ → POINT.
    - Both score edges in the same cycle: no point is awarded → POINT.
    - pause edge → PAUSED. A score edge in the same cycle takes priority over pause.
    - Start edge is ignored.
  - PAUSED (3): out_animate=0.
    - pause edge → PLAY.
    - Score inputs are ignored.
  - POINT (4): out_animate=0. Counter loads POINT_FRAMES.
    - On expiry, if either total equals WIN_POINTS → GAMEOVER. out_winner is set to the side that reached WIN_POINTS.
    - Otherwise → SERVE, with an out_ball_start pulse (the ball engine clears its score flags and re-randomises direction).
  - GAMEOVER (5): out_animate=0. Totals and out_winner are held.
    - start edge → totals cleared, out_winner=00 → SERVE, with out_ball_reset and out_ball_start pulses.
- Encodings 6 and 7 are illegal. They recover to IDLE on the next clock.
- Point arithmetic: 4-bit unsigned. A total never exceeds WIN_POINTS, because the match ends at WIN_POINTS.
- The score-flag edge register keeps updating in every state, so a flag still held high on re-entry to PLAY never produces an edge.

## Timing

- All outputs are registered. Every output is 0 during reset and after reset deasserts. State is IDLE.
- out_ball_start and out_ball_reset pulse for exactly one cycle, in the same cycle the state register shows SERVE.
- out_animate rises in the cycle PLAY is entered, and falls in the cycle PLAY is exited.
- Input edge to state change: 2 cycles (edge register, then state register).
- SERVE duration: the entry cycle plus exactly SERVE_FRAMES strobes. PLAY is entered on the clock after the SERVE_FRAMES-th strobe seen in SERVE. POINT behaves the same with POINT_FRAMES.
- A strobe in the entry cycle of SERVE or POINT does not count.
- Reset asserted mid-match clears all state, totals and pulses asynchronously. No pulse is emitted on exit from reset.

## Test plan

- Reset, then start edge → one out_ball_reset pulse and one out_ball_start pulse; state=1. After 60 strobes: state=2, out_animate=1.
- In PLAY, raise in_right_score and hold it 200 cycles → out_right_points=1 (once), state=4. After 90 strobes: state=1 with a single out_ball_start pulse.
- Left scores 5 times with WIN_POINTS=5 → after the 5th POINT hold: state=5, out_winner=01, out_left_points=5. A start edge then gives totals 0, out_winner=00, state=1, and both pulses.
- Pause edge in PLAY → state=3, out_animate=0. A score edge while paused leaves the totals unchanged. A second pause edge → state=2.
- Left and right score edges in the same cycle → both totals unchanged, state=4. A pause edge coincident with a score edge → state=4.
- Assert in_reset_n low mid-SERVE with left=3 → all outputs 0 immediately. After release: state=0 and no pulses.
